regfile_sb: RTL

Parametrised general-purpose register file for the pipelined CPU core. It extends the basic 2-read/1-write file with a configurable number of read ports, write-back bypass, and a per-register pending-write scoreboard. The scoreboard lets the issue stage detect RAW hazards on destinations with outstanding writes. The block sits between decode/issue (reads and destination reservation) and write-back, and exports a flattened register dump for the debug display.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/sb_counter.sv | 47 ++++
 rtl/regfile_sb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and counter-op encoding for the
// scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

  // Clear dominates; inc and dec together cancel.
  function automatic cnt_op_e cnt_op_sel(
    input logic inc,
    input logic dec,
    input logic clr
  );
    cnt_op_e op;
    op = CNT_HOLD;
    unique case (1'b1)
      clr:               op = CNT_CLR;
      (inc && !dec):     op = CNT_INC;
      (dec && !inc):     op = CNT_DEC;
      default:           op = CNT_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one register,
// with synchronous clear and zero/one/max flags.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic is_zero,
  output logic is_one,
  output logic is_max
);

  localparam logic [PEND_W-1:0] MAX = '1;
  localparam logic [PEND_W-1:0] ONE = PEND_W'(1);

  logic [PEND_W-1:0] cnt;
  cnt_op_e           op;

  assign op = cnt_op_sel(
    (inc && !clr),
    (dec && !clr),
    clr
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      case (op)
        CNT_CLR: cnt <= '0;
        CNT_INC: if (cnt != MAX) cnt <= cnt + ONE;
        CNT_DEC: if (cnt != '0) cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == ONE);
  assign is_max  = (cnt == MAX);

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-back bypass and a
// per-register pending-write scoreboard for RAW detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int PEND_W = 2,
  parameter int BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
  output logic [NUM_RD*DATA_W-1:0]       rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic                           iss_valid,
  input  logic [ADDR_W-1:0]              iss_addr,
  output logic                           iss_ready,
  input  logic                           wb_valid,
  input  logic [ADDR_W-1:0]              wb_addr,
  input  logic [DATA_W-1:0]              wb_data,
  input  logic                           flush,
  output logic                           sb_err,
  output logic [(2**ADDR_W)*DATA_W-1:0]  regs
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [1:DEPTH-1];
  logic [DEPTH-1:0]  c_zero;
  logic [DEPTH-1:0]  c_one;
  logic [DEPTH-1:0]  c_max;
  logic              wb_we;
  logic              iss_acc;
  logic              err_set;

  assign wb_we = wb_valid && (wb_addr != R0);

  // A same-cycle write-back frees a slot on a full counter.
  assign iss_ready = (iss_addr == R0)
                  || !c_max[iss_addr]
                  || (wb_valid && (wb_addr == iss_addr));
  assign iss_acc = iss_valid && iss_ready;

  assign c_zero[0] = 1'b1;
  assign c_one[0]  = 1'b0;
  assign c_max[0]  = 1'b0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_cnt
    logic hit_iss;
    logic hit_wb;

    assign hit_iss = iss_acc && (iss_addr == ADDR_W'(i));
    assign hit_wb  = wb_valid && (wb_addr == ADDR_W'(i));

    sb_counter #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (hit_iss),
      .dec     (hit_wb),
      .clr     (flush),
      .is_zero (c_zero[i]),
      .is_one  (c_one[i]),
      .is_max  (c_max[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wb_we) begin
      mem[wb_addr] <= wb_data;
    end
  end

  assign err_set = wb_we
                && !flush
                && c_zero[wb_addr]
                && !(iss_acc && (iss_addr == wb_addr));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_err <= 1'b0;
    end else if (err_set) begin
      sb_err <= 1'b1;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              byp;
    logic              own_iss;
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    byp     = 1'b0;
    own_iss = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      a       = rd_addr[k*ADDR_W +: ADDR_W];
      byp     = (BYPASS != 0) && wb_valid && (wb_addr == a);
      own_iss = iss_acc && (iss_addr == a);
      if (a != R0) begin
        rd_data[k*DATA_W +: DATA_W] = byp ? wb_data : mem[a];
        // Last outstanding write retiring now resolves the hazard.
        rd_busy[k] = !c_zero[a]
                  && !(byp && c_one[a] && !own_iss);
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 1; i < DEPTH; i++) begin
      regs[i*DATA_W +: DATA_W] = mem[i];
    end
  end

endmodule
